// File: rtl/reset_sequencer.sv
// Multi-domain reset release sequencer: holds all domains in reset until lock, then releases them in order.
// Optional WAIT_ACK watchdog enabled by defining RESET_SEQ_TIMEOUT_EN.
module reset_sequencer #(
    parameter int NUM_STAGES     = 4,
    parameter int HOLD_CYCLES    = 8,
    parameter int DELAY_CYCLES   = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  locked,
    input  logic                  soft_reset,
    input  logic [NUM_STAGES-1:0] stage_ready,
    output logic [NUM_STAGES-1:0] rst_out,
    output logic                  seq_done,
    output logic                  seq_error
);

    localparam int CNT_MAX_HD = (HOLD_CYCLES > DELAY_CYCLES) ? HOLD_CYCLES : DELAY_CYCLES;
    localparam int CNT_MAX    = (CNT_MAX_HD > TIMEOUT_CYCLES) ? CNT_MAX_HD : TIMEOUT_CYCLES;
    localparam int CW         = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int SW         = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

    localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] DELAY_LAST = CW'(DELAY_CYCLES - 1);
    localparam logic [SW-1:0] LAST_STAGE = SW'(NUM_STAGES - 1);

    typedef enum logic [2:0] {
        HOLD,
        WAIT_LOCK,
        DELAY,
        WAIT_ACK,
        DONE
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [SW-1:0] stage;
    logic          lock_lost;

    // Lock only matters once sequencing has started; HOLD and WAIT_LOCK ignore it.
    assign lock_lost = !locked && (state == DELAY || state == WAIT_ACK || state == DONE);

`ifdef RESET_SEQ_TIMEOUT_EN
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
    logic seq_error_q;
    assign seq_error = seq_error_q;
`else
    assign seq_error = 1'b0;
`endif

    // NOTE: all state and outputs update with non-blocking assignments so every
    // register samples the pre-edge values, giving race-free glitch-free outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= HOLD;
            rst_out  <= '1;
            seq_done <= 1'b0;
            stage    <= '0;
            cnt      <= '0;
`ifdef RESET_SEQ_TIMEOUT_EN
            seq_error_q <= 1'b0;
`endif
        end else if (soft_reset) begin
            // Also restarts the HOLD count while soft_reset is held.
            state    <= HOLD;
            rst_out  <= '1;
            seq_done <= 1'b0;
            stage    <= '0;
            cnt      <= '0;
`ifdef RESET_SEQ_TIMEOUT_EN
            seq_error_q <= 1'b0;
`endif
        end else if (lock_lost) begin
            state    <= HOLD;
            rst_out  <= '1;
            seq_done <= 1'b0;
            stage    <= '0;
            cnt      <= '0;
        end else begin
            case (state)
                HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        state <= WAIT_LOCK;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_LOCK: begin
                    if (locked) begin
                        state <= DELAY;
                        stage <= '0;
                        cnt   <= '0;
                    end
                end
                DELAY: begin
                    if (cnt == DELAY_LAST) begin
                        rst_out[stage] <= 1'b0;
                        state          <= WAIT_ACK;
                        cnt            <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_ACK: begin
                    if (stage_ready[stage]) begin
                        cnt <= '0;
                        if (stage == LAST_STAGE) begin
                            state    <= DONE;
                            seq_done <= 1'b1;
                        end else begin
                            stage <= stage + 1'b1;
                            state <= DELAY;
                        end
                    end
`ifdef RESET_SEQ_TIMEOUT_EN
                    else if (cnt == TIMEOUT_LAST) begin
                        // Stuck acknowledge: flag it and retry the whole sequence.
                        state       <= HOLD;
                        rst_out     <= '1;
                        seq_done    <= 1'b0;
                        stage       <= '0;
                        cnt         <= '0;
                        seq_error_q <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
`endif
                end
                DONE: begin
                    rst_out  <= '0;
                    seq_done <= 1'b1;
                end
                default: begin
                    state    <= HOLD;
                    rst_out  <= '1;
                    seq_done <= 1'b0;
                    stage    <= '0;
                    cnt      <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed self-checking bench for reset_sequencer with default stage/hold/delay and a 32-cycle watchdog.
module tb_reset_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       locked = 1'b0;
    logic       soft_reset = 1'b0;
    logic [3:0] stage_ready = 4'b0000;
    logic [3:0] rst_out;
    logic       seq_done;
    logic       seq_error;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    reset_sequencer #(
        .NUM_STAGES    (4),
        .HOLD_CYCLES   (8),
        .DELAY_CYCLES  (16),
        .TIMEOUT_CYCLES(32)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .locked     (locked),
        .soft_reset (soft_reset),
        .stage_ready(stage_ready),
        .rst_out    (rst_out),
        .seq_done   (seq_done),
        .seq_error  (seq_error)
    );

    always #5 clk = ~clk;

    // Expected rst_out c cycles after entering HOLD, with lock and all acks high.
    function automatic logic [3:0] exp_rst(input int c);
        logic [3:0] r;
        for (int k = 0; k < 4; k++) r[k] = (c < 8 + 1 + (k + 1) * 16 + k);
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset(input logic lk, input logic [3:0] rdy);
        reset       = 1'b1;
        soft_reset  = 1'b0;
        locked      = lk;
        stage_ready = rdy;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        cyc   = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if (rst_out !== 4'b1111 || seq_done !== 1'b0 || seq_error !== 1'b0) begin
            bad++;
            $display("FAIL reset_state rst_out=%b done=%b err=%b expected 1111/0/0", rst_out, seq_done, seq_error);
        end
    endtask

    task automatic test_nominal();
        do_reset(1'b1, 4'b1111);
        for (int c = 0; c <= 85; c++) begin
            total++;
            if (rst_out !== exp_rst(c) || seq_done !== (c >= 77) || seq_error !== 1'b0) begin
                bad++;
                $display("FAIL nominal cyc=%0d rst_out=%b done=%b err=%b expected %b/%b/0",
                         c, rst_out, seq_done, seq_error, exp_rst(c), (c >= 77));
            end
            step();
        end
    endtask

    task automatic test_lock_loss_done();
        // Entered from DONE left by test_nominal.
        locked = 1'b0;
        step();
        locked = 1'b1;
        total++;
        if (rst_out !== 4'b1111 || seq_done !== 1'b0) begin
            bad++;
            $display("FAIL lock_loss_restart rst_out=%b done=%b expected 1111/0", rst_out, seq_done);
        end
        for (int c = 0; c <= 80; c++) begin
            total++;
            if (rst_out !== exp_rst(c) || seq_done !== (c >= 77)) begin
                bad++;
                $display("FAIL lock_loss_reseq c=%0d rst_out=%b done=%b expected %b/%b",
                         c, rst_out, seq_done, exp_rst(c), (c >= 77));
            end
            step();
        end
    endtask

    task automatic test_lock_late();
        logic [3:0] e;
        do_reset(1'b0, 4'b1111);
        for (int c = 0; c <= 60; c++) begin
            locked = (c >= 40);
            e = (c >= 57) ? 4'b1110 : 4'b1111;
            total++;
            if (rst_out !== e) begin
                bad++;
                $display("FAIL lock_late cyc=%0d rst_out=%b expected %b", c, rst_out, e);
            end
            step();
        end
    endtask

    task automatic test_ready_stall();
        logic [3:0] e;
        do_reset(1'b1, 4'b1011);
        for (int c = 0; c <= 378; c++) begin
            stage_ready[2] = (c >= 359);
            if (c >= 376)      e = 4'b0000;
            else if (c >= 59)  e = 4'b1000;
            else               e = exp_rst(c);
            if (c >= 40) begin
                total++;
                if (rst_out !== e || seq_done !== (c >= 377)) begin
                    bad++;
                    $display("FAIL ready_stall cyc=%0d rst_out=%b done=%b expected %b/%b",
                             c, rst_out, seq_done, e, (c >= 377));
                end
            end
            step();
        end
    endtask

    task automatic test_soft_reset_delay();
        do_reset(1'b1, 4'b1111);
        while (cyc < 50) step();
        total++;
        if (rst_out !== 4'b1100) begin
            bad++;
            $display("FAIL soft_pre cyc=%0d rst_out=%b expected 1100", cyc, rst_out);
        end
        soft_reset = 1'b1;
        step();
        soft_reset = 1'b0;
        for (int c = 0; c <= 30; c++) begin
            total++;
            if (rst_out !== exp_rst(c) || seq_done !== 1'b0) begin
                bad++;
                $display("FAIL soft_reseq c=%0d rst_out=%b done=%b expected %b/0", c, rst_out, seq_done, exp_rst(c));
            end
            step();
        end
    endtask

    task automatic test_soft_held();
        logic [3:0] e;
        do_reset(1'b1, 4'b1111);
        for (int c = 0; c <= 37; c++) begin
            soft_reset = (c >= 5 && c <= 9);
            e = (c >= 35) ? 4'b1110 : 4'b1111;
            total++;
            if (rst_out !== e) begin
                bad++;
                $display("FAIL soft_held cyc=%0d rst_out=%b expected %b", c, rst_out, e);
            end
            step();
        end
        soft_reset = 1'b0;
    endtask

`ifdef RESET_SEQ_TIMEOUT_EN
    task automatic test_timeout();
        logic [3:0] e;
        do_reset(1'b1, 4'b1101);
        for (int c = 40; c <= 110; c++) begin
            while (cyc < c) step();
            if (c >= 74)      e = exp_rst(c - 74);
            else if (c >= 42) e = 4'b1100;
            else              e = exp_rst(c);
            total++;
            if (rst_out !== e || seq_error !== (c >= 74)) begin
                bad++;
                $display("FAIL timeout cyc=%0d rst_out=%b err=%b expected %b/%b", c, rst_out, seq_error, e, (c >= 74));
            end
        end
        soft_reset = 1'b1;
        step();
        soft_reset = 1'b0;
        total++;
        if (seq_error !== 1'b0 || rst_out !== 4'b1111) begin
            bad++;
            $display("FAIL timeout_clear err=%b rst_out=%b expected 0/1111", seq_error, rst_out);
        end
    endtask
`else
    task automatic test_no_timeout();
        do_reset(1'b1, 4'b1101);
        for (int c = 0; c <= 1200; c++) begin
            if (c >= 42 && (c % 50 == 0 || c == 1200)) begin
                total++;
                if (rst_out !== 4'b1100 || seq_error !== 1'b0 || seq_done !== 1'b0) begin
                    bad++;
                    $display("FAIL no_timeout cyc=%0d rst_out=%b err=%b done=%b expected 1100/0/0",
                             c, rst_out, seq_error, seq_done);
                end
            end
            step();
        end
    endtask
`endif

    initial begin
        test_reset();
        test_nominal();
        test_lock_loss_done();
        test_lock_late();
        test_ready_stall();
        test_soft_reset_delay();
        test_soft_held();
`ifdef RESET_SEQ_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
